// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types and defaults for the matrix-vector multiply sequencer
// Contents: state_t (sequencer states), default K and LAT, datapath word widths.

package mvm_pkg;

    localparam int K_DEF   = 3;
    localparam int LAT_DEF = 2;
    localparam int IN_W    = 14;
    localparam int OUT_W   = 28;

    typedef enum logic [2:0] {
        S_FIRST  = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_X = 3'd2,
        S_MAC    = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

endpackage

// File: rtl/mvm_delay_line.sv
// rtl/mvm_delay_line.sv - LAT-deep shift register aligning accumulator strobes with the MAC pipeline
// Ports: clk, reset (sync, active-high), din (strobes at issue time), dout (strobes LAT cycles later).

module mvm_delay_line
    import mvm_pkg::*;
#(
    parameter int LAT = LAT_DEF,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[LAT-1];

endmodule

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - control FSM sequencing a KxK matrix-vector multiply with matrix reuse
// Ports: clk, reset (sync, active-high); input_valid/input_ready/new_matrix (word intake);
//        output_valid/output_ready (row results); wr_en_w, wr_en_x, w_addr, x_addr (memories);
//        acc_clr, acc_en (accumulator). Build option MVM_SEQ_CTRL_DBG_EN adds
//        dbg_state, dbg_row, dbg_cnt, dbg_delay observation ports.

module mvm_seq_ctrl
    import mvm_pkg::*;
#(
    parameter int K   = K_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       input_valid,
    output logic                       input_ready,
    input  logic                       new_matrix,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic                       wr_en_w,
    output logic                       wr_en_x,
    output logic [$clog2(K*K)-1:0]     w_addr,
    output logic [$clog2(K)-1:0]       x_addr,
    output logic                       acc_clr,
    output logic                       acc_en
`ifdef MVM_SEQ_CTRL_DBG_EN
    ,
    output logic [2:0]                 dbg_state,
    output logic [$clog2(K)-1:0]       dbg_row,
    output logic [$clog2(K*K)-1:0]     dbg_cnt,
    output logic [$clog2(LAT+1)-1:0]   dbg_delay
`endif
);

    localparam int WAW = $clog2(K*K);
    localparam int XAW = $clog2(K);
    localparam int DW  = $clog2(LAT+1);

    state_t          state;
    logic            w_loaded;
    logic [WAW-1:0]  w_cnt;
    logic [XAW-1:0]  x_cnt;
    logic [XAW-1:0]  row;
    logic [XAW-1:0]  col;
    logic [DW-1:0]   dly;
    logic            accept;
    logic            to_w;
    logic            issue;

    always_comb begin
        input_ready  = !reset && (state == S_FIRST || state == S_LOAD_W || state == S_LOAD_X);
        accept       = input_valid && input_ready;
        // A first word without a stored matrix is always a matrix word.
        to_w         = (state == S_FIRST && (new_matrix || !w_loaded)) || state == S_LOAD_W;
        wr_en_w      = accept && to_w;
        wr_en_x      = accept && !to_w;
        issue        = (state == S_MAC);
        output_valid = (state == S_OUT);
        w_addr       = '0;
        x_addr       = '0;
        if (issue) begin
            w_addr = WAW'(int'(row) * K + int'(col));
            x_addr = col;
        end else if (state == S_FIRST || state == S_LOAD_W || state == S_LOAD_X) begin
            w_addr = w_cnt;
            x_addr = x_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FIRST;
            w_loaded <= 1'b0;
            w_cnt    <= '0;
            x_cnt    <= '0;
            row      <= '0;
            col      <= '0;
            dly      <= '0;
        end else begin
            case (state)
                S_FIRST: if (accept) begin
                    if (to_w) begin
                        w_cnt <= WAW'(1);
                        state <= S_LOAD_W;
                    end else begin
                        x_cnt <= XAW'(1);
                        state <= S_LOAD_X;
                    end
                end
                S_LOAD_W: if (accept) begin
                    if (w_cnt == WAW'(K*K-1)) begin
                        w_cnt    <= '0;
                        w_loaded <= 1'b1;
                        state    <= S_LOAD_X;
                    end else begin
                        w_cnt <= w_cnt + WAW'(1);
                    end
                end
                S_LOAD_X: if (accept) begin
                    if (x_cnt == XAW'(K-1)) begin
                        x_cnt <= '0;
                        row   <= '0;
                        col   <= '0;
                        state <= S_MAC;
                    end else begin
                        x_cnt <= x_cnt + XAW'(1);
                    end
                end
                S_MAC: begin
                    if (col == XAW'(K-1)) begin
                        col   <= '0;
                        dly   <= '0;
                        state <= S_WAIT;
                    end else begin
                        col <= col + XAW'(1);
                    end
                end
                // Lets the last product of the row land before the result is shown.
                S_WAIT: begin
                    if (dly == DW'(LAT-1)) state <= S_OUT;
                    else                   dly   <= dly + DW'(1);
                end
                S_OUT: if (output_ready) begin
                    if (row == XAW'(K-1)) begin
                        row   <= '0;
                        state <= S_FIRST;
                    end else begin
                        row   <= row + XAW'(1);
                        state <= S_MAC;
                    end
                end
                default: state <= S_FIRST;
            endcase
        end
    end

    mvm_delay_line #(
        .LAT (LAT),
        .W   (2)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({issue, issue && col == '0}),
        .dout  ({acc_en, acc_clr})
    );

`ifdef MVM_SEQ_CTRL_DBG_EN
    always_comb begin
        dbg_state = state;
        dbg_row   = row;
        dbg_delay = dly;
        case (state)
            S_LOAD_W: dbg_cnt = w_cnt;
            S_LOAD_X: dbg_cnt = WAW'(x_cnt);
            S_MAC:    dbg_cnt = WAW'(col);
            default:  dbg_cnt = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - self-checking bench for mvm_seq_ctrl with a behavioural problem model

module tb_mvm_seq_ctrl;

    localparam int K   = 3;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic        new_matrix = 1'b0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic        wr_en_w, wr_en_x;
    logic [3:0]  w_addr;
    logic [1:0]  x_addr;
    logic        acc_clr, acc_en;
    logic [13:0] din = '0;

    mvm_seq_ctrl #(.K(K), .LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .new_matrix   (new_matrix),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .wr_en_w      (wr_en_w),
        .wr_en_x      (wr_en_x),
        .w_addr       (w_addr),
        .x_addr       (x_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] data;
        logic        nm;
        bit          is_w;
        int          idx;
    } word_t;

    word_t       word_q[$];
    logic [27:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: matrix kept as plain arrays, results as sums of products.
    logic [13:0] m_w [K][K];
    bit          m_loaded = 0;

    task automatic gen_problem(input bit nm);
        bit          force_w;
        logic [13:0] xv [K];
        logic [27:0] y;
        force_w = nm || !m_loaded;
        if (force_w) begin
            for (int i = 0; i < K*K; i++) begin
                word_t it;
                it.data = 14'($urandom);
                it.nm   = (i == 0) ? nm : 1'($urandom);
                it.is_w = 1;
                it.idx  = i;
                m_w[i / K][i % K] = it.data;
                word_q.push_back(it);
            end
            m_loaded = 1;
        end
        for (int i = 0; i < K; i++) begin
            word_t it;
            it.data = 14'($urandom);
            it.nm   = (i == 0 && !force_w) ? nm : 1'($urandom);
            it.is_w = 0;
            it.idx  = i;
            xv[i]   = it.data;
            word_q.push_back(it);
        end
        for (int r = 0; r < K; r++) begin
            y = '0;
            for (int c = 0; c < K; c++) y += 28'(m_w[r][c]) * 28'(xv[c]);
            exp_q.push_back(y);
        end
    endtask

    // Stimulus driver, changed just after each rising edge.
    int vp = 100, rp = 100;
    bit hold_en = 0;
    int hold_cnt = 0;
    int rows_done = 0;

    always @(posedge clk) begin
        #1;
        if (word_q.size() > 0 && $urandom_range(99) < vp) begin
            input_valid = 1'b1;
            din         = word_q[0].data;
            new_matrix  = word_q[0].nm;
        end else begin
            input_valid = 1'b0;
            din         = 14'($urandom);
            new_matrix  = 1'($urandom);
        end
        if (hold_en && rows_done == 1 && output_valid && hold_cnt < 10) begin
            output_ready = 1'b0;
            hold_cnt++;
        end else begin
            output_ready = ($urandom_range(99) < rp);
        end
    end

    // Monitor with a behavioural memory + accumulator harness, sampled on the falling edge.
    logic [13:0] bw [K*K];
    logic [13:0] bx [K];
    logic [3:0]  hist_w [16];
    logic [1:0]  hist_x [16];
    logic [27:0] acc_v = '0;
    int cyc = 0;
    int pend_out = -1, pend_clr = -1;
    int n_hs = 0;
    bit prev_ov = 0, prev_rdy = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_ov   = 0;
            prev_rdy  = 0;
            rows_done = 0;
        end else begin
            hist_w[cyc % 16] = w_addr;
            hist_x[cyc % 16] = x_addr;
            if (input_valid && input_ready && word_q.size() > 0) begin
                word_t it;
                it = word_q.pop_front();
                check_val(it.is_w ? "wr_sel_w" : "wr_sel_x", {wr_en_w, wr_en_x}, it.is_w ? 2'b10 : 2'b01);
                check_val(it.is_w ? "w_addr" : "x_addr", it.is_w ? 32'(w_addr) : 32'(x_addr), it.idx);
                if (it.is_w) bw[it.idx] = it.data;
                else         bx[it.idx] = it.data;
                if (!it.is_w && it.idx == K-1) begin
                    pend_out = cyc + 1 + K + LAT;
                    pend_clr = cyc + 1 + LAT;
                end
            end else begin
                check_val("wr_idle", {wr_en_w, wr_en_x}, 2'b00);
            end
            if (acc_en) begin
                logic [27:0] p;
                p = 28'(bw[hist_w[(cyc - LAT) % 16]]) * 28'(bx[hist_x[(cyc - LAT) % 16]]);
                acc_v = acc_clr ? p : acc_v + p;
            end
            if (acc_clr) begin
                check_val("clr_time", cyc, pend_clr);
                check_val("clr_implies_en", acc_en, 1);
            end
            if (output_valid && !prev_ov) check_val("out_time", cyc, pend_out);
            if (prev_ov && !prev_rdy) check_val("out_hold", output_valid, 1);
            if (output_valid) begin
                check_val("frozen_acc", {acc_en, acc_clr}, 2'b00);
                if (output_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_output", 1, 0);
                    end else begin
                        check_val("result", acc_v, exp_q.pop_front());
                    end
                    n_hs++;
                    rows_done++;
                    if (rows_done == K) begin
                        rows_done = 0;
                    end else begin
                        pend_out = cyc + 1 + K + LAT;
                        pend_clr = cyc + 1 + LAT;
                    end
                end
            end
            prev_ov  = output_valid;
            prev_rdy = output_ready;
        end
    end

    task automatic wait_drain(input bit words_only, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = words_only ? (word_q.size() == 0) : (word_q.size() == 0 && exp_q.size() == 0);
        end
        check_val("drain", done, 1);
    endtask

    initial begin
        int base;
        bit seen;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_outs", {input_ready, output_valid, wr_en_w, wr_en_x, acc_clr, acc_en, w_addr, x_addr}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // No matrix stored: a reuse request right after reset loads a matrix.
        gen_problem(0);
        wait_drain(0, 500);
        // Fresh matrix, then reuse of it.
        gen_problem(1);
        wait_drain(0, 500);
        gen_problem(0);
        wait_drain(0, 500);

        // Output backpressure on row 1.
        hold_en  = 1;
        hold_cnt = 0;
        gen_problem(0);
        wait_drain(0, 500);
        check_val("hold_len", hold_cnt, 10);
        hold_en = 0;

        // Reset while row 1 waits for its last product.
        base = n_hs;
        gen_problem(1);
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (n_hs == base + 1);
        end
        check_val("row0_seen", seen, 1);
        repeat (K + 1) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("midrst_outs", {input_ready, output_valid, wr_en_w, wr_en_x, acc_clr, acc_en, w_addr, x_addr}, 0);
        word_q.delete();
        exp_q.delete();
        m_loaded = 0;
        pend_out = -1;
        pend_clr = -1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 check_val("midrst_ready", input_ready, 1);
        gen_problem(0);
        wait_drain(0, 500);

        // Randomized handshakes.
        vp = 50;
        rp = 50;
        for (int p = 0; p < 1000; p++) begin
            wait_drain(1, 2000);
            gen_problem($urandom_range(99) < 30);
        end
        wait_drain(0, 2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Control FSM that sequences the K×K matrix–vector multiply datapath with matrix reuse. It accepts a stream of 14-bit words over a valid/ready handshake and writes them into the W (matrix) and X (vector) memories. A `new_matrix` flag on the first word of each problem selects between loading a fresh matrix and reusing the stored one. It then issues the read addresses and accumulator controls, and presents each of the K results on a valid/ready output handshake. The datapath it drives is the memories, the MAC pipeline and the accumulator/output register.

## Interface
- K, 3: matrix dimension; K ≥ 2.
- LAT, 2: cycles from read-address issue to the accumulator-update cycle (1 memory + 1 multiply); LAT ≥ 1.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- input_valid  in  1  producer has a word on the datapath input bus.
- input_ready  out  1  controller can accept a word this cycle.
- new_matrix  in  1  sampled only with the first word of a problem.
- output_valid  out  1  accumulator holds a finished row result.
- output_ready  in  1  consumer takes the result this cycle.
- wr_en_w  out  1  write the current input word into W.
- wr_en_x  out  1  write the current input word into X.
- w_addr  out  $clog2(K*K)  W write/read address.
- x_addr  out  $clog2(K)  X write/read address.
- acc_clr  out  1  accumulator loads the product (first term of a row).
- acc_en  out  1  accumulator adds the product.

## Operation
- Accept rule: a word is accepted when input_valid && input_ready at a rising edge; wr_en_w and wr_en_x equal accept gated by state.
- input_ready is 1 only in S_FIRST, S_LOAD_W and S_LOAD_X, and is forced 0 while reset is high.
- A flag w_loaded is cleared by reset and set when the K*K-th W word is written.
- S_FIRST: on accept, if new_matrix || !w_loaded, write W[0] and go to S_LOAD_W. Otherwise write X[0] and go to S_LOAD_X. A word with new_matrix=0 and no matrix stored is treated as a matrix word.
- S_LOAD_W: on each accept, write W[w_cnt]. After W[K*K-1], set w_loaded and go to S_LOAD_X. new_matrix is ignored in this state.
- S_LOAD_X: on each accept, write X[x_cnt]. After X[K-1], go to S_MAC with row=0 and col=0.
- S_MAC: one issue per cycle with w_addr=row*K+col and x_addr=col. After col=K-1, go to S_WAIT.
- S_WAIT: hold for exactly LAT cycles, then go to S_OUT.
- S_OUT: output_valid=1 and the accumulator is frozen.
  - On output_ready, if row==K-1 go to S_FIRST.
  - Otherwise row++ and go to S_MAC.
- Accumulator controls:
  - acc_en is the S_MAC issue strobe delayed by LAT.
  - acc_clr is (issue && col==0) delayed by LAT; acc_clr implies acc_en.
- Idle values: w_addr and x_addr show the write counters during load states, otherwise 0.
- Reset values: state S_FIRST, all counters 0, w_loaded 0, delay line cleared, and every output 0.
- Reset mid-operation: the problem is abandoned with no partial output. The next accepted word must carry new_matrix=1 or is forced to a matrix load.

## Timing
- Let E0 be the edge that accepts X[K-1]. Then:
  - S_MAC occupies cycles 0..K-1 after E0.
  - The last acc_en is in cycle K-1+LAT.
  - output_valid first appears in cycle K+LAT (cycle 5 for K=3, LAT=2).
- Output handshake at edge En puts the next row's first issue in cycle n+1.
- Unstalled throughput:
  - Per vector: K*(K+LAT+1) cycles (18 at defaults).
  - Plus K input cycles, plus K*K input cycles when the matrix is new.
- output_valid holds with a stable result until output_ready. No output is dropped or duplicated.
- The input bus may carry X while input_valid=0; nothing is written then.

## Configuration
- MVM_SEQ_CTRL_DBG_EN defined: adds these output ports:
  - dbg_state (state enum).
  - dbg_row ($clog2(K)).
  - dbg_cnt (active load or col counter).
  - dbg_delay ($clog2(LAT+1)).
- MVM_SEQ_CTRL_DBG_EN undefined: those ports and their logic are absent. Functional behaviour is identical in both builds.

## Structure
- Package mvm_pkg holds:
  - The state enum: S_FIRST, S_LOAD_W, S_LOAD_X, S_MAC, S_WAIT, S_OUT.
  - Default K and LAT.
  - Data widths: input 14, output 28.
- Sub-module mvm_delay_line: LAT-deep synchronous-reset shift register carrying {acc_en, acc_clr}.

## Test plan
- New matrix, K=3: send 9 W words (first with new_matrix=1) then 3 X words, output_ready=1.
  - 9 wr_en_w pulses at addresses 0..8, then 3 wr_en_x pulses at 0..2.
  - output_valid in cycle 5 after the last X accept.
  - 3 outputs spaced 6 cycles apart.
- Reuse: after the above, send 3 X words with new_matrix=0 on the first.
  - No wr_en_w; wr_en_x at 0..2; 3 outputs read W addresses 0..8.
- No matrix stored: immediately after reset, first word has new_matrix=0.
  - The word goes to W[0]; all 12 words are consumed as a matrix load.
- Output backpressure: hold output_ready=0 for 10 cycles on row 1.
  - output_valid stays 1 and acc_en/acc_clr stay 0.
  - Row 2 issue starts the cycle after the handshake.
- Random valid/ready: 50% input_valid and output_ready over 1000 problems with 30% new matrices.
  - Outputs match the reference model in order.
- Reset mid-compute: assert reset during S_WAIT of row 1.
  - Next cycle, all outputs are 0 and the state is S_FIRST.
  - A following reuse request is forced to a matrix load.
